// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
// It grants one byte per frame, drives that requester's frame format, pulses start and tracks tx_busy.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16,
    localparam int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [5*NUM_REQ-1:0] req_cfg,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic [4:0]           tx_cfg,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 arb_idle,
    output logic                 start_err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t            state, state_n;
    logic [ID_W-1:0]   last_grant, last_grant_n;
    logic [ID_W-1:0]   grant_id_n;
    logic [7:0]        tx_data_n;
    logic [4:0]        tx_cfg_n;
    logic [NUM_REQ-1:0] req_ready_n;
    logic              tx_start_n;
    logic              start_err_n;
    logic              arb_idle_n;
    logic [7:0]        busy_cnt, busy_cnt_n;

    logic [7:0]        data_arr [NUM_REQ];
    logic [4:0]        cfg_arr  [NUM_REQ];
    logic              found;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cand;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[8*g +: 8];
        assign cfg_arr[g]  = req_cfg[5*g +: 5];
    end

    // First valid requester searching upward from the one after last_grant.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        grant_id_n   = grant_id;
        tx_data_n    = tx_data;
        tx_cfg_n     = tx_cfg;
        req_ready_n  = '0;
        tx_start_n   = 1'b0;
        start_err_n  = 1'b0;
        busy_cnt_n   = busy_cnt;
        unique case (state)
            IDLE: begin
                if (!tx_busy && found) begin
                    state_n      = LOAD;
                    last_grant_n = winner;
                    grant_id_n   = winner;
                    tx_data_n    = data_arr[winner];
                    tx_cfg_n     = cfg_arr[winner];
                    req_ready_n  = NUM_REQ'(1) << winner;
                end
            end
            LOAD: begin
                state_n    = START;
                tx_start_n = 1'b1;
            end
            START: begin
                busy_cnt_n = '0;
                state_n    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                end else begin
                    busy_cnt_n = busy_cnt + 8'd1;
                    if (busy_cnt_n == 8'(BUSY_TIMEOUT)) begin
                        start_err_n = 1'b1;
                        state_n     = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Outputs are registered, so idle reflects the state being entered.
        arb_idle_n = (state_n == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            grant_id   <= '0;
            tx_data    <= 8'h00;
            tx_cfg     <= 5'b01011;
            req_ready  <= '0;
            tx_start   <= 1'b0;
            start_err  <= 1'b0;
            arb_idle   <= 1'b1;
            busy_cnt   <= '0;
        end else begin
            state      <= state_n;
            last_grant <= last_grant_n;
            grant_id   <= grant_id_n;
            tx_data    <= tx_data_n;
            tx_cfg     <= tx_cfg_n;
            req_ready  <= req_ready_n;
            tx_start   <= tx_start_n;
            start_err  <= start_err_n;
            arb_idle   <= arb_idle_n;
            busy_cnt   <= busy_cnt_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requesters and a transmitter busy model drive the DUT,
// and a frame-timeline reference model predicts every output each cycle.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [8*NR-1:0] req_data;
    logic [5*NR-1:0] req_cfg;
    logic [NR-1:0] req_ready;
    logic [7:0]    tx_data;
    logic [4:0]    tx_cfg;
    logic          tx_start;
    logic          tx_busy;
    logic [1:0]    grant_id;
    logic          arb_idle;
    logic          start_err;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_cfg   (req_cfg),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_cfg    (tx_cfg),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .arb_idle  (arb_idle),
        .start_err (start_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: where the arbiter is in the frame timeline
    // 0 free, 1 accepting, 2 starting, 3 awaiting busy rise, 4 awaiting busy fall.
    int          m_phase;
    int          m_last;
    int          m_wait;
    logic [NR-1:0] e_ready;
    logic        e_start, e_err, e_idle;
    logic [7:0]  e_data;
    logic [4:0]  e_cfg;
    int          e_gid;

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++)
            if (v[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    task automatic model_step(input logic r, input logic [NR-1:0] v, input logic b);
        int w;
        e_ready = '0;
        e_start = 1'b0;
        e_err   = 1'b0;
        if (r) begin
            m_phase = 0;
            m_last  = NR - 1;
            m_wait  = 0;
            e_data  = 8'h00;
            e_cfg   = 5'b01011;
            e_gid   = 0;
        end else begin
            case (m_phase)
                0: begin
                    w = rr_pick(v, m_last);
                    if (!b && w >= 0) begin
                        m_last     = w;
                        e_gid      = w;
                        e_data     = req_data[8*w +: 8];
                        e_cfg      = req_cfg[5*w +: 5];
                        e_ready[w] = 1'b1;
                        m_phase    = 1;
                    end
                end
                1: begin
                    e_start = 1'b1;
                    m_phase = 2;
                end
                2: begin
                    m_wait  = 0;
                    m_phase = 3;
                end
                3: begin
                    if (b) m_phase = 4;
                    else begin
                        m_wait++;
                        if (m_wait == TO) begin
                            e_err   = 1'b1;
                            m_phase = 0;
                        end
                    end
                end
                default: if (!b) m_phase = 0;
            endcase
        end
        e_idle = (m_phase == 0);
    endtask

    int          rise_in  = -1;
    int          busy_len = 0;
    logic [NR-1:0] en;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_cfg   = '0;
        tx_busy   = 1'b0;
        en        = '1;
        model_step(1'b1, req_valid, tx_busy);

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            check_eq("req_ready", 32'(req_ready), 32'(e_ready));
            check_eq("tx_start",  32'(tx_start),  32'(e_start));
            check_eq("start_err", 32'(start_err), 32'(e_err));
            check_eq("arb_idle",  32'(arb_idle),  32'(e_idle));
            check_eq("tx_data",   32'(tx_data),   32'(e_data));
            check_eq("tx_cfg",    32'(tx_cfg),    32'(e_cfg));
            check_eq("grant_id",  32'(grant_id),  32'(e_gid));

            if (cyc % 400 == 0) en = NR'($urandom_range(1, (1 << NR) - 1));

            // Requesters hold data/cfg until they see ready; staying valid after ready is a new byte.
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    req_valid[i] = en[i] && ($urandom_range(0, 2) != 0);
                    req_data[8*i +: 8] = 8'($urandom);
                    req_cfg[5*i +: 5]  = 5'($urandom);
                end else if (!req_valid[i] && en[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                    req_cfg[5*i +: 5]  = 5'($urandom);
                end
            end

            // Transmitter: most starts raise busy after 0..3 cycles; the rest never do.
            if (tx_start) begin
                if ($urandom_range(0, 4) != 0) begin
                    rise_in  = $urandom_range(0, 3);
                    busy_len = $urandom_range(1, 20);
                end
            end else if (m_phase == 0 && rise_in < 0 && $urandom_range(0, 15) == 0) begin
                rise_in  = 0;
                busy_len = $urandom_range(1, 6);
            end
            if (rise_in > 0) begin
                rise_in--;
                tx_busy = 1'b0;
            end else if (rise_in == 0 && busy_len > 0) begin
                tx_busy = 1'b1;
                busy_len--;
            end else begin
                tx_busy = 1'b0;
                rise_in = -1;
            end

            rst = (cyc < 2) || ($urandom_range(0, 299) == 0);
            model_step(rst, req_valid, tx_busy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
